// File: rtl/toggle_pulse_tx.sv
// ---------------------------------------------------------------------------
// toggle_pulse_tx
//
// Transmit half of a multi-channel toggle synchronizer. Every single-cycle
// event on sel_i[i] becomes one level toggle on pol_o[i]. A channel issues a
// new toggle only after the receiver has echoed the previous one back on
// ack_tgl_i[i]. Events that arrive while the channel is busy are counted and
// replayed later; when the counter saturates, further events are dropped and
// flagged.
//
// Optional feature (macro TOGGLE_PULSE_TX_TIMEOUT_EN):
//   A per-channel counter tracks how long a toggle has been in flight and
//   raises a sticky to_err_o[i] once it reaches 2^TO_W-1. Without the macro
//   to_err_o is held low and the port list is unchanged.
//
// Handshake: pol_o[i] != ack_tgl_i[i] means a toggle is in flight. The
// receiver acknowledges by making ack_tgl_i[i] equal to pol_o[i] again.
// ack_tgl_i must already be synchronized into clk.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   sel_i       per-channel event pulse (one event per cycle high)
//   ack_tgl_i   toggle echoed by the receiver (already in clk domain)
//   err_clr_i   per-channel clear of the sticky ovf_o / to_err_o flags
//   pol_o       outgoing toggle level
//   busy_o      toggle in flight (pol_o ^ ack_tgl_i, combinational)
//   pend_cnt_o  pending-event count, channel i at [i*CNT_W +: CNT_W]
//   ovf_o       sticky: an event was dropped because pend was saturated
//   to_err_o    sticky: ack timeout (optional feature, else 0)
// ---------------------------------------------------------------------------
module toggle_pulse_tx #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned TO_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     sel_i,
  input  logic [NCH-1:0]     ack_tgl_i,
  input  logic [NCH-1:0]     err_clr_i,
  output logic [NCH-1:0]     pol_o,
  output logic [NCH-1:0]     busy_o,
  output logic [NCH*CNT_W-1:0] pend_cnt_o,
  output logic [NCH-1:0]     ovf_o,
  output logic [NCH-1:0]     to_err_o
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             pol_q, pol_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             busy;
    logic             launch;
    logic             drop;

    always_comb begin
      busy   = pol_q ^ ack_tgl_i[i];
      launch = !busy && (sel_i[i] || (pend_q != '0));
      // Only a busy channel can refuse an event, so a drop needs pend at max.
      drop   = sel_i[i] && !launch && (pend_q == PEND_MAX);
      pol_d  = pol_q ^ launch;

      // pend + sel - launch, with the saturating case leaving pend at max.
      pend_d = pend_q;
      if (sel_i[i] && !launch && !drop) begin
        pend_d = pend_q + 1'b1;
      end else if (!sel_i[i] && launch) begin
        pend_d = pend_q - 1'b1;
      end

      // Clear first so a simultaneous set overrides it.
      ovf_d = ovf_q;
      if (err_clr_i[i]) ovf_d = 1'b0;
      if (drop)         ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pol_q  <= 1'b0;
        pend_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        pol_q  <= pol_d;
        pend_q <= pend_d;
        ovf_q  <= ovf_d;
      end
    end

    assign pol_o[i]                       = pol_q;
    assign busy_o[i]                      = busy;
    assign pend_cnt_o[i*CNT_W +: CNT_W]   = pend_q;
    assign ovf_o[i]                       = ovf_q;

`ifdef TOGGLE_PULSE_TX_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_MAX = '1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_err_q, to_err_d;

    always_comb begin
      to_cnt_d = '0;
      if (busy) begin
        to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
      end
      to_err_d = to_err_q;
      if (err_clr_i[i])       to_err_d = 1'b0;
      // Flag on the same edge the counter lands on max; stays asserted while
      // the channel remains stuck busy.
      if (to_cnt_d == TO_MAX) to_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        to_cnt_q <= '0;
        to_err_q <= 1'b0;
      end else begin
        to_cnt_q <= to_cnt_d;
        to_err_q <= to_err_d;
      end
    end

    assign to_err_o[i] = to_err_q;
`else
    // No timeout logic: the flag is constant low for any legal TO_W.
    assign to_err_o[i] = (TO_W == 0);
`endif
  end

endmodule

// File: tb/tb_toggle_pulse_tx.sv
// ---------------------------------------------------------------------------
// tb_toggle_pulse_tx
//
// Directed bench for toggle_pulse_tx (NCH=4, CNT_W=3, TO_W=4). Inputs are
// driven 1 time unit after the rising edge and outputs are checked at the
// same point, i.e. they show the post-edge register state.
// ---------------------------------------------------------------------------
module tb_toggle_pulse_tx;
  localparam int NCH   = 4;
  localparam int CNT_W = 3;
  localparam int TO_W  = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       sel;
  logic [NCH-1:0]       ack_tgl;
  logic [NCH-1:0]       err_clr;
  logic [NCH-1:0]       pol;
  logic [NCH-1:0]       busy;
  logic [NCH*CNT_W-1:0] pend_cnt;
  logic [NCH-1:0]       ovf;
  logic [NCH-1:0]       to_err;

  int n_vec = 0;
  int n_err = 0;

  toggle_pulse_tx #(.NCH(NCH), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel_i      (sel),
    .ack_tgl_i  (ack_tgl),
    .err_clr_i  (err_clr),
    .pol_o      (pol),
    .busy_o     (busy),
    .pend_cnt_o (pend_cnt),
    .ovf_o      (ovf),
    .to_err_o   (to_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    sel     = '0;
    ack_tgl = '0;
    err_clr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [CNT_W-1:0] pend_of(input int ch);
    return pend_cnt[ch*CNT_W +: CNT_W];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int         tog;
    int         peak;
    logic       prev;
    logic [4:0] hist;
    logic       exp_to;

    // Reset with every channel requesting
    rst_n   = 1'b0;
    sel     = 4'hF;
    ack_tgl = '0;
    err_clr = '0;
    tick();
    check("rst_pol_a",  32'(pol),      32'h0);
    check("rst_pend_a", 32'(pend_cnt), 32'h0);
    check("rst_ovf_a",  32'(ovf),      32'h0);
    check("rst_toerr",  32'(to_err),   32'h0);
    tick();
    check("rst_pol_b",  32'(pol),      32'h0);
    check("rst_pend_b", 32'(pend_cnt), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rel_pol",    32'(pol),      32'hF);
    check("rel_busy",   32'(busy),     32'hF);
    check("rel_pend",   32'(pend_cnt), 32'h0);
    do_reset();

    // Ch0 single event, echo after 3 busy cycles
    sel[0] = 1'b1;
    tick();
    sel[0] = 1'b0;
    check("c0_pol_n1",  32'(pol[0]),    32'h1);
    check("c0_busy_n1", 32'(busy[0]),   32'h1);
    check("c0_pend_n1", 32'(pend_of(0)), 32'h0);
    tick();
    check("c0_busy_n2", 32'(busy[0]),   32'h1);
    tick();
    check("c0_busy_n3", 32'(busy[0]),   32'h1);
    check("c0_pend_n3", 32'(pend_of(0)), 32'h0);
    ack_tgl[0] = 1'b1;
    #1;
    check("c0_ack_busy", 32'(busy[0]),  32'h0);
    tick();
    check("c0_pol_hold", 32'(pol[0]),   32'h1);
    check("c0_pend_end", 32'(pend_of(0)), 32'h0);

    // Ch1 five back-to-back events, receiver echoes through a 5-deep delay
    tog  = 0;
    peak = 0;
    prev = pol[1];
    hist = '0;
    for (int c = 0; c < 40; c++) begin
      sel[1] = (c < 5);
      tick();
      if (pol[1] != prev) tog++;
      prev = pol[1];
      if (int'(pend_of(1)) > peak) peak = int'(pend_of(1));
      hist       = {hist[3:0], pol[1]};
      ack_tgl[1] = hist[4];
    end
    sel[1] = 1'b0;
    check("c1_toggles", 32'(tog),        32'd5);
    check("c1_peak",    32'(peak),       32'd4);
    check("c1_pend_end", 32'(pend_of(1)), 32'h0);
    check("c1_ovf",     32'(ovf[1]),     32'h0);
    check("c1_busy_end", 32'(busy[1]),   32'h0);
    check("c1_pol_end", 32'(pol[1]),     32'h1);
    check("c1_ch0_iso", 32'(pol[0]),     32'h1);

    // Ch2 saturation with ack withheld
    sel[2] = 1'b1;
    tick();
    check("c2_launch", 32'(pol[2]), 32'h1);
    for (int k = 0; k < 7; k++) tick();
    check("c2_pend7",     32'(pend_of(2)), 32'd7);
    check("c2_ovf_pre",   32'(ovf[2]),     32'h0);
    tick();
    sel[2] = 1'b0;
    check("c2_pend_sat",  32'(pend_of(2)), 32'd7);
    check("c2_ovf_set",   32'(ovf[2]),     32'h1);
    tog  = 1;
    prev = pol[2];
    for (int c = 0; c < 40; c++) begin
      ack_tgl[2] = pol[2];
      tick();
      if (pol[2] != prev) tog++;
      prev = pol[2];
    end
    ack_tgl[2] = pol[2];
    check("c2_toggles",  32'(tog),        32'd8);
    check("c2_pend_end", 32'(pend_of(2)), 32'h0);
    check("c2_pol_end",  32'(pol[2]),     32'h0);
    check("c2_ovf_stky", 32'(ovf[2]),     32'h1);
    err_clr[2] = 1'b1;
    tick();
    err_clr[2] = 1'b0;
    check("c2_ovf_clr",  32'(ovf[2]),     32'h0);

    // Ch3 event coincident with ack while pend=2, then clear-vs-set
    sel[3] = 1'b1;
    tick();
    tick();
    tick();
    sel[3] = 1'b0;
    check("c3_pol_a",  32'(pol[3]),     32'h1);
    check("c3_pend2",  32'(pend_of(3)), 32'd2);
    ack_tgl[3] = 1'b1;
    sel[3]     = 1'b1;
    tick();
    check("c3_coin_pol",  32'(pol[3]),     32'h0);
    check("c3_coin_pend", 32'(pend_of(3)), 32'd2);
    for (int k = 0; k < 5; k++) tick();
    check("c3_pend7",  32'(pend_of(3)), 32'd7);
    check("c3_ovf0",   32'(ovf[3]),     32'h0);
    tick();
    check("c3_ovf1",   32'(ovf[3]),     32'h1);
    err_clr[3] = 1'b1;
    tick();
    check("c3_setwins", 32'(ovf[3]),     32'h1);
    check("c3_pend_sat", 32'(pend_of(3)), 32'd7);
    sel[3] = 1'b0;
    tick();
    err_clr[3] = 1'b0;
    check("c3_ovf_clr", 32'(ovf[3]),     32'h0);

    // Ack timeout on ch0 after a fresh reset
`ifdef TOGGLE_PULSE_TX_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    do_reset();
    sel[0] = 1'b1;
    tick();
    sel[0] = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    check("to_before", 32'(to_err[0]), 32'h0);
    tick();
    check("to_at15",   32'(to_err[0]), 32'(exp_to));
    check("to_others", 32'(to_err[3:1]), 32'h0);
    ack_tgl[0] = 1'b1;
    err_clr[0] = 1'b1;
    tick();
    err_clr[0] = 1'b0;
    check("to_clr",    32'(to_err[0]), 32'h0);
    check("to_pol",    32'(pol[0]),    32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/toggle_pulse_tx.md
Name: toggle_pulse_tx

Overview:
- Multi-channel transmit side of the toggle synchronizer.
- Each channel converts single-cycle event pulses into level toggles on pol[i], one toggle per event.
- A new toggle is issued only after the receiver has echoed the previous one back on ack_tgl[i]. ack_tgl is already synchronized into clk.
- Events arriving while a channel is busy are counted and replayed later, so none are lost until the counter saturates.

Parameters:
- NCH, 4: number of independent channels.
- CNT_W, 3: width of the per-channel pending-event counter. Max pending = 2^CNT_W-1.
- TO_W, 8: width of the ack timeout counter. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- sel  in  NCH  per-channel event pulse, one event per cycle high
- ack_tgl  in  NCH  returned toggle from receiver, already synchronized to clk
- err_clr  in  NCH  per-channel clear of sticky error flags
- pol  out  NCH  outgoing toggle level
- busy  out  NCH  pol[i] != ack_tgl[i], toggle in flight
- pend_cnt  out  NCH*CNT_W  pending count; channel i at bits [i*CNT_W +: CNT_W]
- ovf  out  NCH  sticky: event dropped due to saturation
- to_err  out  NCH  sticky ack timeout (optional feature)

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: pol=0, pend_cnt=0, ovf=0, to_err=0. Timeout counters = 0.
- Reset mid-operation discards all pending events and in-flight state. The receiver must also reset, so ack_tgl returns to 0.
- Channels are fully independent; no shared arbitration.
- Per channel i, per cycle:
  - busy = pol ^ ack_tgl, combinational from the registers and the input.
  - launch = !busy && (sel || pend != 0).
  - When launch is high, pol toggles at the next edge.
- Latency: sel high at cycle N with the channel idle and pend=0 gives pol toggled at N+1 and busy high from N+1.
- Pending counter update: pend_next = pend + sel - launch.
  - sel && launch with pend>0: pend unchanged; the oldest pending event is launched and the new one queued.
  - sel && launch with pend==0: the event launches directly; pend stays 0.
- Saturation: pend==MAX && sel && !launch gives pend stays MAX, the event is dropped and ovf[i] sets.
- Ack detection: when ack_tgl[i] changes to equal pol[i], busy falls in the same cycle. If pend>0, launch fires in that cycle, giving minimum spacing of one toggle per handshake round trip.
- Spurious ack (ack_tgl changes while the channel is idle) makes busy high. No launch happens until ack_tgl matches pol again. Events queue meanwhile; no error flag.
- err_clr[i] clears ovf[i] and to_err[i] at the next edge. If err_clr and a new set condition occur in the same cycle, set wins.
- pend_cnt is registered and reflects the post-edge value.

Optional Feature:
- Macro: TOGGLE_PULSE_TX_TIMEOUT_EN.
- With macro:
  - A per-channel TO_W-bit counter increments every cycle busy[i] is high and clears when busy[i] is low.
  - On reaching 2^TO_W-1 it sets to_err[i] sticky and holds at max.
  - Recovery is via err_clr or reset only; the toggle state itself is unchanged.
- Without macro: no timeout counters; to_err is tied to 0; port list unchanged.

Test Plan:
- Reset with sel=4'hF held -> pol=0, pend_cnt=0, ovf=0 throughout reset; after release, pol=4'hF one cycle later.
- Ch0 single sel pulse, ack_tgl[0] echoed 3 cycles later -> pol[0] 0->1 at N+1, busy[0] high 3 cycles, pend 0 throughout.
- Ch1 five back-to-back sel pulses, ack delay 4 cycles -> exactly 5 pol[1] toggles total, pend peaks at 4 and drains to 0, ovf[1]=0.
- CNT_W=3, ch2 busy with ack withheld, 8 further sel pulses -> pend_cnt[2]=7, ovf[2]=1. Releasing acks gives 1+7=8 toggles. err_clr[2] with no new overflow -> ovf[2]=0 next cycle.
- Ch3 sel coincident with the ack arrival while pend=2 -> one launch that cycle, pend stays 2; err_clr and saturating sel in the same cycle -> ovf stays 1.
- With TOGGLE_PULSE_TX_TIMEOUT_EN and TO_W=4, ack withheld -> to_err set after 15 busy cycles; without the macro -> to_err remains 0.
